// File: rtl/bus_port_fifo.sv
// rtl/bus_port_fifo.sv - bus port with address-filtered RX FIFO and FWFT TX FIFO
module bus_port_fifo #(
    parameter int          pckg_sz    = 16,
    parameter int          fifo_depth = 16,
    parameter logic [7:0]  id         = 8'h00,
    parameter logic [7:0]  broadcast  = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    // bus side of the TX FIFO
    output logic                          pndng,
    output logic [pckg_sz-1:0]            D_pop,
    input  logic                          pop,
    // bus side of the RX FIFO
    input  logic                          push,
    input  logic [pckg_sz-1:0]            D_push,
    // device side of the TX FIFO
    input  logic                          tx_wr,
    input  logic [pckg_sz-1:0]            tx_data,
    output logic                          tx_full,
    // device side of the RX FIFO
    input  logic                          rx_rd,
    output logic [pckg_sz-1:0]            rx_data,
    output logic                          rx_valid,
    output logic [$clog2(fifo_depth):0]   rx_count,
    // status
    output logic [7:0]                    tx_ovf_cnt,
    output logic [7:0]                    rx_drop_cnt,
    output logic                          unf_err
);

    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // storage and pointers; the extra MSB of each pointer separates full from empty
    logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
    logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
    logic [AW:0]        r_tx_wptr;
    logic [AW:0]        r_tx_rptr;
    logic [AW:0]        r_rx_wptr;
    logic [AW:0]        r_rx_rptr;
    logic [AW:0]        r_rx_count;
    logic [7:0]         r_tx_ovf_cnt;
    logic [7:0]         r_rx_drop_cnt;
    logic               r_unf_err;

    logic w_tx_empty;
    logic w_tx_full;
    logic w_tx_do_pop;
    logic w_tx_do_wr;
    logic w_tx_ovf;
    logic w_rx_empty;
    logic w_rx_full;
    logic w_rx_match;
    logic w_rx_do_rd;
    logic w_rx_do_wr;
    logic w_rx_drop;

    assign w_tx_empty  = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full   = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                         (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_tx_do_pop = pop && !w_tx_empty;
    // a pop in the same cycle frees the slot, so a write into a full FIFO still lands
    assign w_tx_do_wr  = tx_wr && (!w_tx_full || w_tx_do_pop);
    assign w_tx_ovf    = tx_wr && !w_tx_do_wr;

    assign w_rx_empty  = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full   = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                         (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
    assign w_rx_match  = (D_push[pckg_sz-1 -: 8] == id) ||
                         (D_push[pckg_sz-1 -: 8] == broadcast);
    assign w_rx_do_rd  = rx_rd && !w_rx_empty;
    assign w_rx_do_wr  = push && w_rx_match && (!w_rx_full || w_rx_do_rd);
    assign w_rx_drop   = push && !w_rx_do_wr;

    // first-word fall-through heads, forced to zero when empty
    assign pndng       = !w_tx_empty;
    assign D_pop       = w_tx_empty ? '0 : r_tx_mem[r_tx_rptr[AW-1:0]];
    assign tx_full     = w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr[AW-1:0]];
    assign rx_count    = r_rx_count;
    assign tx_ovf_cnt  = r_tx_ovf_cnt;
    assign rx_drop_cnt = r_rx_drop_cnt;
    assign unf_err     = r_unf_err;

    // FIFO data arrays; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (!reset && w_tx_do_wr)
            r_tx_mem[r_tx_wptr[AW-1:0]] <= tx_data;
        if (!reset && w_rx_do_wr)
            r_rx_mem[r_rx_wptr[AW-1:0]] <= D_push;
    end

    // TX pointers, overflow counter and sticky underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr    <= '0;
            r_tx_rptr    <= '0;
            r_tx_ovf_cnt <= '0;
            r_unf_err    <= 1'b0;
        end else begin
            if (w_tx_do_wr)
                r_tx_wptr <= r_tx_wptr + PTR_ONE;
            if (w_tx_do_pop)
                r_tx_rptr <= r_tx_rptr + PTR_ONE;
            if (w_tx_ovf && (r_tx_ovf_cnt != 8'hFF))
                r_tx_ovf_cnt <= r_tx_ovf_cnt + 8'd1;
            if (pop && w_tx_empty)
                r_unf_err <= 1'b1;
        end
    end

    // RX pointers, occupancy and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wptr     <= '0;
            r_rx_rptr     <= '0;
            r_rx_count    <= '0;
            r_rx_drop_cnt <= '0;
        end else begin
            if (w_rx_do_wr)
                r_rx_wptr <= r_rx_wptr + PTR_ONE;
            if (w_rx_do_rd)
                r_rx_rptr <= r_rx_rptr + PTR_ONE;
            case ({w_rx_do_wr, w_rx_do_rd})
                2'b10:   r_rx_count <= r_rx_count + PTR_ONE;
                2'b01:   r_rx_count <= r_rx_count - PTR_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
            if (w_rx_drop && (r_rx_drop_cnt != 8'hFF))
                r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
        end
    end

endmodule
